// File: rtl/pool_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pool_ctrl_pkg
// Shared definitions for the max-pooling controller: the controller state
// encoding, default parameter values and a counter-width helper.
// DATA_WIDTH defaults from the global define POOL_DATA_WIDTH (32 when the
// build does not set it).
// -----------------------------------------------------------------------------
`ifndef POOL_DATA_WIDTH
`define POOL_DATA_WIDTH 32
`endif

package pool_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = `POOL_DATA_WIDTH;
    localparam int DEF_POOL_K     = 2;
    localparam int DEF_NUM_WIN    = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_ACC  = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4
    } pool_state_e;

    // $clog2 sizing, but never narrower than one bit so that a count of one
    // (single window, 1x1 pool) still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pooling_max_ctrl_if.sv
// -----------------------------------------------------------------------------
// pooling_max_ctrl_if
// Bundles the pixel stream, the external max-cell link, the pooled output
// stream and the frame status of the max-pooling controller.
//   master : the surrounding system (stream source/sink, max cell, sequencer)
//   slave  : the controller (pooling_max_ctrl)
// Signals:
//   start              frame start request (one cycle)
//   in_data/in_valid   window-ordered pixel stream, in_ready back-pressure
//   cell_a/cell_clear  operand and clear towards the external max cell
//   cell_result        registered running maximum from the cell
//   out_data/out_valid pooled maximum, out_ready back-pressure
//   busy/done          frame in progress / end-of-frame pulse
// -----------------------------------------------------------------------------
interface pooling_max_ctrl_if
    import pool_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  start;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] cell_a;
    logic                  cell_clear;
    logic [DATA_WIDTH-1:0] cell_result;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport master (
        output start, in_data, in_valid, cell_result, out_ready,
        input  in_ready, cell_a, cell_clear, out_data, out_valid, busy, done
    );

    modport slave (
        input  start, in_data, in_valid, cell_result, out_ready,
        output in_ready, cell_a, cell_clear, out_data, out_valid, busy, done
    );

endinterface

// File: rtl/pooling_max_ctrl.sv
// -----------------------------------------------------------------------------
// pooling_max_ctrl
// Sequences an external running-max cell over a frame of NUM_WIN pooling
// windows of POOL_K*POOL_K non-negative IEEE-754 pixels each, emitting one
// maximum per window.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   pooling_max_ctrl_if.slave (stream in, max-cell link, stream out,
//         busy/done)
//   win_idx (only with POOL_STATUS_EN defined) current window number,
//         0 while idle
// Per window: CLR clears the cell, ACC forwards accepted pixels to it, WAIT
// lets the cell register the last pixel, OUT presents the result until the
// downstream handshake.
// -----------------------------------------------------------------------------
module pooling_max_ctrl
    import pool_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int POOL_K     = DEF_POOL_K,
    parameter  int NUM_WIN    = DEF_NUM_WIN,
    localparam int WIN_W      = cnt_width(NUM_WIN)
) (
    input  logic             clk,
    input  logic             rst,
    pooling_max_ctrl_if.slave bus
`ifdef POOL_STATUS_EN
    ,
    output logic [WIN_W-1:0] win_idx
`endif
);

    localparam int                    NEL       = POOL_K * POOL_K;
    localparam int                    EL_W      = cnt_width(NEL);
    localparam logic [EL_W-1:0]       EL_LAST   = EL_W'(NEL - 1);
    localparam logic [WIN_W-1:0]      WIN_LAST  = WIN_W'(NUM_WIN - 1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

    pool_state_e      state_q, state_d;
    logic [EL_W-1:0]  el_cnt_q, el_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            el_cnt_q  <= '0;
            win_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            el_cnt_q  <= el_cnt_d;
            win_cnt_q <= win_cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        el_cnt_d        = el_cnt_q;
        win_cnt_d       = win_cnt_q;
        done_d          = 1'b0;
        bus.in_ready    = 1'b0;
        bus.cell_clear  = 1'b0;
        bus.cell_a      = DATA_ZERO;
        bus.out_valid   = 1'b0;
        bus.out_data    = DATA_ZERO;
        bus.busy        = 1'b1;

        case (state_q)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    win_cnt_d = '0;
                    state_d   = ST_CLR;
                end
            end

            ST_CLR: begin
                bus.cell_clear = 1'b1;
                el_cnt_d       = '0;
                state_d        = ST_ACC;
            end

            ST_ACC: begin
                bus.in_ready = 1'b1;
                // Zero is the neutral operand for a non-negative stream, so
                // idle cycles leave the running max untouched.
                if (bus.in_valid) begin
                    bus.cell_a = bus.in_data;
                    if (el_cnt_q == EL_LAST) begin
                        state_d = ST_WAIT;
                    end else begin
                        el_cnt_d = el_cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                state_d = ST_OUT;
            end

            ST_OUT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = bus.cell_result;
                if (bus.out_ready) begin
                    if (win_cnt_q == WIN_LAST) begin
                        // Window count returns to 0 so it reads 0 while idle.
                        win_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        state_d   = ST_CLR;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.done = done_q;

`ifdef POOL_STATUS_EN
    assign win_idx = win_cnt_q;
`endif

endmodule

// File: tb/tb_pooling_max_ctrl.sv
module tb_pooling_max_ctrl;
    import pool_ctrl_pkg::*;

    localparam int DW    = 32;
    localparam int K     = 2;
    localparam int NW    = 2;
    localparam int NEL   = K * K;
    localparam int WIN_W = cnt_width(NW);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pooling_max_ctrl_if #(.DATA_WIDTH(DW)) bus ();

`ifdef POOL_STATUS_EN
    logic [WIN_W-1:0] win_idx;
`endif

    pooling_max_ctrl #(
        .DATA_WIDTH (DW),
        .POOL_K     (K),
        .NUM_WIN    (NW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef POOL_STATUS_EN
        ,
        .win_idx (win_idx)
`endif
    );

    // External running-max cell; unsigned ordering equals float ordering for
    // non-negative IEEE-754 values.
    logic [DW-1:0] cell_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cell_q <= '0;
        else if (bus.cell_clear)     cell_q <= '0;
        else if (bus.cell_a > cell_q) cell_q <= bus.cell_a;
    end
    assign bus.cell_result = cell_q;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] pix [NW*NEL];

    // Reference: maximum of a window taken straight from the pixel table.
    function automatic logic [DW-1:0] ref_max(input int w);
        logic [DW-1:0] m;
        m = '0;
        for (int e = 0; e < NEL; e++)
            if (pix[w*NEL+e] > m) m = pix[w*NEL+e];
        return m;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rdy"}, bus.in_ready, 0);
        chk({tag, "_clr"}, bus.cell_clear, 0);
        chk({tag, "_ov"}, bus.out_valid, 0);
        chk({tag, "_od"}, bus.out_data, 0);
        chk({tag, "_ca"}, bus.cell_a, 0);
`ifdef POOL_STATUS_EN
        chk({tag, "_win"}, win_idx, 0);
`endif
    endtask

    task automatic run_frame(input int gap_len, input int stall_len, input bit glitch);
        logic [DW-1:0] exp;
        @(negedge clk);
        chk("pre_busy", bus.busy, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int w = 0; w < NW; w++) begin
            chk("clr_pulse", bus.cell_clear, 1);
            chk("clr_busy", bus.busy, 1);
            chk("clr_rdy", bus.in_ready, 0);
`ifdef POOL_STATUS_EN
            chk("win_idx", win_idx, w);
`endif
            @(negedge clk);
            for (int e = 0; e < NEL; e++) begin
                if (e == 2) begin
                    for (int g = 0; g < gap_len; g++) begin
                        bus.in_valid = 1'b0;
                        bus.in_data  = $urandom;
                        bus.start    = glitch && (g == 0);
                        #1;
                        chk("gap_rdy", bus.in_ready, 1);
                        chk("gap_ca", bus.cell_a, 0);
                        @(negedge clk);
                        bus.start = 1'b0;
                        chk("gap_noclr", bus.cell_clear, 0);
                    end
                end
                bus.in_valid = 1'b1;
                bus.in_data  = pix[w*NEL+e];
                #1;
                chk("acc_rdy", bus.in_ready, 1);
                chk("acc_ca", bus.cell_a, pix[w*NEL+e]);
                chk("acc_ov", bus.out_valid, 0);
                @(negedge clk);
            end
            // Offer junk while not ready: it must not reach the cell.
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom & 32'h7F7F_FFFF;
            #1;
            chk("wait_rdy", bus.in_ready, 0);
            chk("wait_ca", bus.cell_a, 0);
            chk("wait_ov", bus.out_valid, 0);
            @(negedge clk);
            exp = ref_max(w);
            chk("lat_ov", bus.out_valid, 1);
            chk("out_data", bus.out_data, exp);
            chk("out_rdy", bus.in_ready, 0);
            for (int s = 0; s < stall_len; s++) begin
                @(negedge clk);
                chk("stall_ov", bus.out_valid, 1);
                chk("stall_od", bus.out_data, exp);
                chk("stall_rdy", bus.in_ready, 0);
                chk("stall_clr", bus.cell_clear, 0);
                chk("stall_ca", bus.cell_a, 0);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            chk("post_ov", bus.out_valid, 0);
            if (w == NW - 1) begin
                chk("done", bus.done, 1);
                chk("end_busy", bus.busy, 0);
                @(negedge clk);
                chk("done_pulse", bus.done, 0);
                chk_idle("end");
            end else begin
                chk("mid_done", bus.done, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("rst");
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("post_rst");
        chk("post_rst_done", bus.done, 0);

        // 1.0,3.0,2.0,0.5 then 0.5,0.25,2.0,0.0
        pix[0] = 32'h3F80_0000; pix[1] = 32'h4040_0000;
        pix[2] = 32'h4000_0000; pix[3] = 32'h3F00_0000;
        pix[4] = 32'h3F00_0000; pix[5] = 32'h3E80_0000;
        pix[6] = 32'h4000_0000; pix[7] = 32'h0000_0000;
        run_frame(0, 0, 1'b0);

        // 4.0,1.0,1.0,1.0 then 0.5,0.25,2.0,0.0 with gap, stall, stray start
        pix[0] = 32'h4080_0000; pix[1] = 32'h3F80_0000;
        pix[2] = 32'h3F80_0000; pix[3] = 32'h3F80_0000;
        run_frame(3, 5, 1'b1);

        // Reset in the middle of accumulation
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        for (int e = 0; e < 2; e++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h7F00_0000;
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_done", bus.done, 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("after_mid_rst");

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NW*NEL; i++)
                pix[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'h7F7F_FFFF);
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pooling_max_ctrl.md
POOLING_MAX_CTRL -- requirements
Module: pooling_max_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: pixel word width (IEEE-754 single).
REQ-002 SHALL have parameter POOL_K, default 2: window side; each window holds POOL_K*POOL_K elements.
REQ-003 SHALL have parameter NUM_WIN, default 16: windows per frame.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle frame start request.
REQ-007 SHALL have port in_data  in  DATA_WIDTH  window-ordered pixel stream.
REQ-008 SHALL have port in_valid  in  1  in_data valid.
REQ-009 SHALL have port in_ready  out  1  controller accepts in_data.
REQ-010 SHALL have port cell_a  out  DATA_WIDTH  operand to external max cell.
REQ-011 SHALL have port cell_clear  out  1  clear to external max cell.
REQ-012 SHALL have port cell_result  in  DATA_WIDTH  registered running max from the cell.
REQ-013 SHALL have port out_data  out  DATA_WIDTH  pooled maximum.
REQ-014 SHALL have port out_valid  out  1  out_data valid.
REQ-015 SHALL have port out_ready  in  1  downstream accepts out_data.
REQ-016 SHALL have port busy  out  1  frame in progress.
REQ-017 SHALL have port done  out  1  one-cycle pulse after the last window's output handshake.

Function
REQ-018 SHALL implement states IDLE, CLR, ACC, WAIT, OUT.
REQ-019 IDLE: in_ready=0, busy=0; start=1 -> CLR with window count 0; start outside IDLE SHALL be ignored.
REQ-020 CLR: cell_clear=1 for exactly one cycle, element count set to 0, -> ACC.
REQ-021 ACC: in_ready=1; accept = in_valid&in_ready; cell_a=in_data on accept, else cell_a=0 (neutral; stream is non-negative post-ReLU).
REQ-022 ACC: element count increments per accept; accept at count POOL_K*POOL_K-1 -> WAIT; in_valid gaps SHALL stall without affecting the max.
REQ-023 WAIT: one cycle with in_ready=0 and cell_a=0, allowing cell_result to register the final element; -> OUT.
REQ-024 OUT: out_valid=1, out_data=cell_result held stable until out_valid&out_ready.
REQ-025 On OUT handshake: window count < NUM_WIN-1 -> increment, CLR; otherwise done=1 next cycle, -> IDLE.
REQ-026 Latency: out_valid SHALL rise exactly 2 cycles after the accepting edge of a window's last element.
REQ-027 Counters SHALL be $clog2 sized and SHALL never wrap inside a frame.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, counts 0, and in_ready, cell_clear, out_valid, busy, done 0, with cell_a and out_data 0, including mid-frame; partial window discarded.
REQ-030 After rst deasserts, no output SHALL change until start.

Configuration
REQ-031 With POOL_STATUS_EN defined, SHALL add output win_idx ($clog2(NUM_WIN) bits) equal to the current window count, 0 in IDLE and reset.
REQ-032 Without POOL_STATUS_EN, win_idx SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-033 State enum and default parameter constants SHALL live in shared package pool_ctrl_pkg; DATA_WIDTH SHALL default from the global define.
REQ-034 No sub-module; the max cell SHALL be instantiated alongside, not inside, this block.

Verification
REQ-035 NUM_WIN=1, POOL_K=2, inputs 1.0,3.0,2.0,0.5 back-to-back, out_ready=1 -> out_data=3.0 two cycles after last accept; done one cycle after handshake.
REQ-036 NUM_WIN=2, inputs 4.0,1.0,1.0,1.0 then 0.5,0.25,2.0,0.0 -> outputs 4.0 then 2.0; cell_clear pulses twice.
REQ-037 in_valid low 3 cycles between elements 2 and 3 -> same result as without gaps; in_ready stays 1.
REQ-038 out_ready low 5 cycles in OUT -> out_data stable, in_ready=0, next window not started.
REQ-039 start pulsed during ACC -> ignored; rst asserted mid-ACC -> all outputs 0 immediately; new start gives a correct fresh frame.
REQ-040 With POOL_STATUS_EN, NUM_WIN=4 -> win_idx steps 0,1,2,3, returns 0 in IDLE.
